mac_block_accum: RTL and testbench
==================================

Name: mac_block_accum

Overview:
- Downstream consumer of the multiply-add pipeline's 16-bit result stream (data_out = a*b + c).
- Groups every N_SAMPLES accepted results into one block.
- For each block, produces the sum, maximum and minimum of the results.
- Each block result is presented on a registered valid/ready output, so a slow sink stalls the upstream producer through in_ready.

Parameters:
- DATA_W, 16: width of incoming result samples (unsigned).
- N_SAMPLES, 4: samples per block; legal range 1..255.
- ACC_W, 24: sum width; must be >= DATA_W + clog2(N_SAMPLES). Elaboration-time assertion on violation.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_data holds a valid sample
- in_ready  out  1  block can accept a sample this cycle
- in_data  in  DATA_W  result sample from the multiply-add pipeline
- clear  in  1  synchronous abort of the current block and of any pending output
- out_valid  out  1  out_sum/out_max/out_min hold a completed block
- out_ready  in  1  sink accepts the block this cycle
- out_sum  out  ACC_W  sum of N_SAMPLES samples, zero-extended
- out_max  out  DATA_W  largest sample in the block
- out_min  out  DATA_W  smallest sample in the block
- block_cnt  out  8  count of blocks handed off; wraps 255->0

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - out_valid=0, out_sum=0, out_max=0, out_min=0, block_cnt=0, internal sample count=0.
  - in_ready is 0 while rst_n=0 and 1 from the first cycle after release.
- Transfers:
  - Input accept = in_valid & in_ready.
  - Output handoff = out_valid & out_ready.
  - All arithmetic is unsigned.
- in_ready = (state != HOLD) | out_ready. A new block may start in the same cycle as a handoff, so there is no bubble between blocks.
- States:
  - IDLE: on accept, sum=in_data, max=min=in_data, cnt=1. Go to ACCUM, or to HOLD if N_SAMPLES==1.
  - ACCUM: on accept, sum+=in_data, max=max(max,in_data), min=min(min,in_data), cnt++. Without an accept, hold all state (gaps in in_valid are allowed). On the accept that makes cnt==N_SAMPLES, load the output registers with the final values including that sample, set out_valid=1 and go to HOLD.
  - HOLD: out_* stay stable until handoff.
    - Handoff without accept: out_valid=0, block_cnt++, go to IDLE.
    - Handoff with accept: block_cnt++, the accepted sample seeds a new block as in IDLE, next state ACCUM. If N_SAMPLES==1, out_* reload and out_valid stays 1.
- Latency: out_valid rises on the cycle after the Nth accept.
  - At full rate with out_ready held at 1, one block completes every N_SAMPLES cycles.
- clear has priority over every other event in the cycle:
  - Next state IDLE, cnt=0, out_valid=0.
  - Partial accumulation and any pending output are discarded.
  - block_cnt is unchanged. Any sample presented that cycle is dropped; in_ready stays as computed.
- Equal samples: max and min both equal the sample value.
- Widths: no overflow is possible given the ACC_W constraint.
- Wrap: block_cnt wraps modulo 256; no flag is raised.
- Output stability: out_sum/out_max/out_min change only when out_valid rises or on a same-cycle reload. They are never glitched by accumulation.

Decomposition:
- Shared package mac_pkg:
  - DATA_W constant.
  - State enum typedef for IDLE/ACCUM/HOLD.
  - clog2-based minimum-width function used by the ACC_W assertion.
- Sub-module minmax_track:
  - Holds the running max/min registers.
  - Inputs: seed, update, sample.
  - Instantiated once.
  - Everything else lives in the top module.

Test Plan:
- Full-rate stream, N=4, out_ready=1, samples 10,20,30,40 -> out_valid for 1 cycle, one cycle after the 4th accept; out_sum=100, out_max=40, out_min=10, block_cnt=1.
- Back-pressure: block done, out_ready=0 for 5 cycles, in_valid=1 -> in_ready=0 for 5 cycles and out_* stable. When out_ready rises, the next sample is accepted the same cycle, and block_cnt increments exactly once.
- Gappy input: samples 65535 x4 with in_valid toggling 1,0 -> out_sum=262140 (0x03FFFC), out_max=out_min=65535.
- clear asserted after 2 of 4 samples, then 1,2,3,4 -> out_sum=10, block_cnt unchanged by the aborted block. clear in HOLD -> out_valid drops the next cycle with no handoff counted.
- Reset mid-block (rst_n low between clock edges) -> all outputs 0 immediately. After release, a fresh block 5,5,5,5 gives out_sum=20.
- N_SAMPLES=1 with continuous stream 7,3 and out_ready=1 -> out_sum 7 then 3 on consecutive cycles with out_valid held at 1; block_cnt wraps from 255 to 0 after 256 handoffs.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-add result block accumulator.
//   DATA_W     : default width of the incoming result samples
//   state_t    : block FSM states, fixed encodings kept from the legacy RTL
//   min_acc_w(): smallest sum width that cannot overflow for a given block size
package mac_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    function automatic int unsigned min_acc_w(input int unsigned data_w,
                                              input int unsigned n_samples);
        return data_w + $clog2(n_samples);
    endfunction

endpackage

// File: rtl/mac_block_accum_minmax_track.sv
// Running maximum / minimum tracker for one block of samples.
//   clk, rst_n : clock, asynchronous active-low reset (registers clear to 0)
//   seed       : start a new block; both trackers load sample
//   update     : fold sample into the running max/min
//   sample     : incoming sample
//   cur_max/cur_min   : registered running extremes
//   next_max/next_min : extremes including this cycle's sample, so the
//                       parent can capture a final result without a bubble
module minmax_track #(
    parameter int unsigned DATA_W = mac_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed,
    input  logic              update,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] cur_max,
    output logic [DATA_W-1:0] cur_min,
    output logic [DATA_W-1:0] next_max,
    output logic [DATA_W-1:0] next_min
);

    always_comb begin
        next_max = cur_max;
        next_min = cur_min;
        if (seed) begin
            next_max = sample;
            next_min = sample;
        end else if (update) begin
            if (sample > cur_max) next_max = sample;
            if (sample < cur_min) next_min = sample;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_max <= '0;
            cur_min <= '0;
        end else begin
            cur_max <= next_max;
            cur_min <= next_min;
        end
    end

endmodule

// File: rtl/mac_block_accum.sv
// Groups N_SAMPLES accepted multiply-add results into a block and reports
// the block sum, maximum and minimum on a registered valid/ready output.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : sample handshake (in_data)
//   clear               : synchronous abort of partial block and pending output
//   out_valid/out_ready : block result handshake (out_sum, out_max, out_min)
//   block_cnt           : blocks handed off, wraps modulo 256
module mac_block_accum #(
    parameter int unsigned DATA_W    = mac_pkg::DATA_W,
    parameter int unsigned N_SAMPLES = 4,
    parameter int unsigned ACC_W     = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_min,
    output logic [7:0]        block_cnt
);

    import mac_pkg::*;

    if (N_SAMPLES < 1 || N_SAMPLES > 255) begin : g_n_samples_check
        $error("mac_block_accum: N_SAMPLES=%0d outside 1..255", N_SAMPLES);
    end
    if (ACC_W < min_acc_w(DATA_W, N_SAMPLES)) begin : g_acc_w_check
        $error("mac_block_accum: ACC_W=%0d below required %0d",
               ACC_W, min_acc_w(DATA_W, N_SAMPLES));
    end

    localparam logic [7:0] N_LAST = 8'(N_SAMPLES);

    state_t             state;
    logic [7:0]         cnt;
    logic [7:0]         cnt_inc;
    logic [ACC_W-1:0]   sum;
    logic [ACC_W-1:0]   sample_ext;
    logic [ACC_W-1:0]   sum_next;
    logic               accept;
    logic               handoff;
    logic               seed;
    logic               update;
    logic [DATA_W-1:0]  cur_max;
    logic [DATA_W-1:0]  cur_min;
    logic [DATA_W-1:0]  next_max;
    logic [DATA_W-1:0]  next_min;

    assign in_ready   = rst_n & ((state != S_HOLD) | out_ready);
    assign accept     = in_valid & in_ready;
    assign handoff    = out_valid & out_ready;
    assign sample_ext = ACC_W'(in_data);
    assign sum_next   = sum + sample_ext;
    assign cnt_inc    = cnt + 8'd1;

    // Any accept outside ACCUM starts a fresh block.
    assign seed   = accept & (state != S_ACCUM) & ~clear;
    assign update = accept & (state == S_ACCUM) & ~clear;

    minmax_track #(
        .DATA_W (DATA_W)
    ) u_minmax (
        .clk      (clk),
        .rst_n    (rst_n),
        .seed     (seed),
        .update   (update),
        .sample   (in_data),
        .cur_max  (cur_max),
        .cur_min  (cur_min),
        .next_max (next_max),
        .next_min (next_min)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sum       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_max   <= '0;
            out_min   <= '0;
            block_cnt <= '0;
        end else if (clear) begin
            state     <= S_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (handoff) block_cnt <= block_cnt + 8'd1;
            case (state)
                // In HOLD an accept can only occur with out_ready high,
                // so it always coincides with the handoff.
                S_IDLE, S_HOLD: begin
                    if (state == S_HOLD && handoff && !accept) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                    if (accept) begin
                        sum <= sample_ext;
                        cnt <= 8'd1;
                        if (N_SAMPLES == 1) begin
                            out_sum   <= sample_ext;
                            out_max   <= next_max;
                            out_min   <= next_min;
                            out_valid <= 1'b1;
                            state     <= S_HOLD;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        sum <= sum_next;
                        cnt <= cnt_inc;
                        if (cnt_inc == N_LAST) begin
                            out_sum   <= sum_next;
                            out_max   <= next_max;
                            out_min   <= next_min;
                            out_valid <= 1'b1;
                            state     <= S_HOLD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_block_accum.sv
module tb_mac_block_accum;

    typedef struct {
        logic [23:0] sum;
        logic [15:0] mx;
        logic [15:0] mn;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        clear = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] out_sum;
    logic [15:0] out_max;
    logic [15:0] out_min;
    logic [7:0]  block_cnt;

    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [15:0] in_data1 = '0;
    logic        clear1 = 1'b0;
    logic        out_valid1;
    logic        out_ready1 = 1'b1;
    logic [23:0] out_sum1;
    logic [15:0] out_max1;
    logic [15:0] out_min1;
    logic [7:0]  block_cnt1;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t sb1[$];

    always #5 clk = ~clk;

    mac_block_accum #(.DATA_W(16), .N_SAMPLES(4), .ACC_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .clear(clear), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_max(out_max),
        .out_min(out_min), .block_cnt(block_cnt)
    );

    mac_block_accum #(.DATA_W(16), .N_SAMPLES(1), .ACC_W(24)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .clear(clear1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_sum(out_sum1), .out_max(out_max1),
        .out_min(out_min1), .block_cnt(block_cnt1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare each handed-off block against the queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !clear) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_block", 32'(out_sum), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("blk_sum", 32'(out_sum), 32'(e.sum));
                check_eq("blk_max", 32'(out_max), 32'(e.mx));
                check_eq("blk_min", 32'(out_min), 32'(e.mn));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid1 && out_ready1) begin
            if (sb1.size() == 0) begin
                check_eq("sb1_unexpected_block", 32'(out_sum1), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb1.pop_front();
                check_eq("n1_sum", 32'(out_sum1), 32'(e.sum));
                check_eq("n1_max", 32'(out_max1), 32'(e.mx));
                check_eq("n1_min", 32'(out_min1), 32'(e.mn));
            end
        end
    end

    // Present one sample and hold it until accepted (bounded wait).
    task automatic send(input logic [15:0] d);
        int w = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check_eq("accept_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d,
                              input bit gap);
        logic [15:0] s [4];
        exp_t e;
        s[0] = a; s[1] = b; s[2] = c; s[3] = d;
        e.sum = 24'(a) + 24'(b) + 24'(c) + 24'(d);
        e.mx = s[0];
        e.mn = s[0];
        for (int i = 1; i < 4; i++) begin
            if (s[i] > e.mx) e.mx = s[i];
            if (s[i] < e.mn) e.mn = s[i];
        end
        sb.push_back(e);
        for (int i = 0; i < 4; i++) begin
            send(s[i]);
            if (gap && i < 3) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #3;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_sum", 32'(out_sum), 32'd0);
        check_eq("rst_block_cnt", 32'(block_cnt), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Full-rate block, latency and single-cycle out_valid
        out_ready = 1'b1;
        send_block(16'd10, 16'd20, 16'd30, 16'd40, 1'b0);
        check_eq("lat_out_valid", 32'(out_valid), 32'd1);
        tick();
        check_eq("one_cycle_valid", 32'(out_valid), 32'd0);
        check_eq("blk_cnt_1", 32'(block_cnt), 32'd1);

        // Back-pressure
        out_ready = 1'b0;
        send_block(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            check_eq("bp_sum_stable", 32'(out_sum), 32'd10);
            check_eq("bp_valid_held", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        begin
            exp_t e;
            e.sum = 24'd30; e.mx = 16'd9; e.mn = 16'd6;
            sb.push_back(e);
        end
        @(negedge clk);
        check_eq("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_eq("bp_blk_cnt", 32'(block_cnt), 32'd2);
        send(16'd8);
        send(16'd7);
        send(16'd6);
        tick();
        check_eq("bp_blk_cnt_next", 32'(block_cnt), 32'd3);

        // Gappy input at full scale
        send_block(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
        tick();
        check_eq("gap_blk_cnt", 32'(block_cnt), 32'd4);

        // clear mid-block
        send(16'd100);
        send(16'd200);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        send_block(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
        tick();
        check_eq("clr_blk_cnt", 32'(block_cnt), 32'd5);

        // clear while holding a finished block
        out_ready = 1'b0;
        send(16'd5); send(16'd6); send(16'd7); send(16'd8);
        check_eq("hold_valid", 32'(out_valid), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clr_hold_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        tick();
        check_eq("clr_hold_blk_cnt", 32'(block_cnt), 32'd5);

        // Asynchronous reset mid-block
        send(16'd1);
        send(16'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_out_sum", 32'(out_sum), 32'd0);
        check_eq("arst_out_max", 32'(out_max), 32'd0);
        check_eq("arst_out_min", 32'(out_min), 32'd0);
        check_eq("arst_block_cnt", 32'(block_cnt), 32'd0);
        check_eq("arst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        send_block(16'd5, 16'd5, 16'd5, 16'd5, 1'b0);
        tick();
        check_eq("arst_fresh_blk_cnt", 32'(block_cnt), 32'd1);

        // N_SAMPLES=1: continuous stream, block_cnt wrap
        out_ready1 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            logic [15:0] s;
            exp_t e;
            s = (i == 0) ? 16'd7 : (i == 1) ? 16'd3 : 16'(i);
            e.sum = 24'(s); e.mx = s; e.mn = s;
            sb1.push_back(e);
            in_valid1 = 1'b1;
            in_data1  = s;
            tick();
            if (i == 0) begin
                check_eq("n1_first_valid", 32'(out_valid1), 32'd1);
                check_eq("n1_first_sum", 32'(out_sum1), 32'd7);
            end
            if (i == 1) begin
                check_eq("n1_second_valid", 32'(out_valid1), 32'd1);
                check_eq("n1_second_sum", 32'(out_sum1), 32'd3);
            end
        end
        in_valid1 = 1'b0;
        check_eq("n1_blk_cnt_255", 32'(block_cnt1), 32'd255);
        tick();
        check_eq("n1_blk_cnt_wrap", 32'(block_cnt1), 32'd0);
        check_eq("n1_drained_valid", 32'(out_valid1), 32'd0);

        check_eq("sb_left", 32'(sb.size()), 32'd0);
        check_eq("sb1_left", 32'(sb1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
